// File: rtl/mux_pkg.sv
// Shared constants, helper function and storage-state encoding for the
// pipelined select stage.
package mux_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    // Select width for n inputs; a 1-input or 2-input mux still needs one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_t;

endpackage

// File: rtl/mux_skid_buf.sv
// Valid/ready output stage for mux_pipe_n. With MUX_SKID_EN defined it is a
// 2-entry skid buffer with registered in_ready; otherwise a single register.
module mux_skid_buf
    import mux_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

`ifdef MUX_SKID_EN
    skid_state_t      state_reg;
    skid_state_t      state_next;
    logic             ready_reg;
    logic [WIDTH-1:0] out_reg;
    logic [WIDTH-1:0] skid_reg;
    logic             push;
    logic             pop;
    logic             load_out_in;
    logic             load_out_skid;
    logic             load_skid;

    assign push = in_valid && ready_reg;
    assign pop  = (state_reg != EMPTY) && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= EMPTY;
            ready_reg <= 1'b1;
        end else begin
            state_reg <= state_next;
            ready_reg <= (state_next != TWO);
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            EMPTY: if (push) state_next = ONE;
            ONE: begin
                if (push && !pop)
                    state_next = TWO;
                else if (!push && pop)
                    state_next = EMPTY;
            end
            TWO:     if (pop) state_next = ONE;
            default: state_next = EMPTY;
        endcase
    end

    // Load strobes; in TWO the skid word advances as the head drains.
    always_comb begin
        load_out_in   = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        case (state_reg)
            EMPTY: load_out_in = push;
            ONE: begin
                load_out_in = push && pop;
                load_skid   = push && !pop;
            end
            TWO:     load_out_skid = pop;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_reg  <= '0;
            skid_reg <= '0;
        end else begin
            if (load_out_in)
                out_reg <= in_data;
            else if (load_out_skid)
                out_reg <= skid_reg;
            if (load_skid)
                skid_reg <= in_data;
        end
    end

    assign in_ready  = ready_reg;
    assign out_valid = (state_reg != EMPTY);
    assign out_data  = out_reg;
`else
    logic             valid_reg;
    logic [WIDTH-1:0] data_reg;
    logic             push;

    // Free slot now, or the held word leaves on this same edge.
    assign in_ready = !valid_reg || out_ready;
    assign push     = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (push) begin
            valid_reg <= 1'b1;
            data_reg  <= in_data;
        end else if (out_ready) begin
            valid_reg <= 1'b0;
        end
    end

    assign out_valid = valid_reg;
    assign out_data  = data_reg;
`endif

endmodule

// File: rtl/mux_pipe_n.sv
// N-input, WIDTH-bit registered select stage with valid/ready handshake and a
// sticky illegal-select flag. Optional skid buffer: define MUX_SKID_EN.
module mux_pipe_n
    import mux_pkg::*;
#(
    parameter int               WIDTH       = DATA_W,
    parameter int               N_IN        = 4,
    parameter logic [WIDTH-1:0] ILLEGAL_VAL = '0,
    localparam int              SEL_W       = clog2_min1(N_IN)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]      in_sel,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  sel_err,
    input  logic                  err_clr
);

    localparam int SEL_N = 1 << SEL_W;

    // Table covers every select code, so out-of-range codes decode to a
    // defined word and flag instead of reaching past the inputs.
    logic [WIDTH-1:0] sel_word [SEL_N];
    logic [SEL_N-1:0] sel_bad;
    logic [WIDTH-1:0] mux_word;
    logic             mux_bad;
    logic             accept;
    logic             sel_err_reg;

    generate
        for (genvar gi = 0; gi < SEL_N; gi++) begin : g_sel
            if (gi < N_IN) begin : g_legal
                assign sel_word[gi] = in_data[gi*WIDTH +: WIDTH];
                assign sel_bad[gi]  = 1'b0;
            end else begin : g_illegal
                assign sel_word[gi] = ILLEGAL_VAL;
                assign sel_bad[gi]  = 1'b1;
            end
        end
    endgenerate

    assign mux_word = sel_word[in_sel];
    assign mux_bad  = sel_bad[in_sel];
    assign accept   = in_valid && in_ready;

    // Set has priority over a clear on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sel_err_reg <= 1'b0;
        else if (accept && mux_bad)
            sel_err_reg <= 1'b1;
        else if (err_clr)
            sel_err_reg <= 1'b0;
    end

    assign sel_err = sel_err_reg;

    mux_skid_buf #(
        .WIDTH(WIDTH)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .in_data  (mux_word),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

endmodule

// File: doc/mux_pipe_n.md
Name: mux_pipe_n

Overview:
Parametrised N-input, W-bit select stage with a registered output and a valid/ready handshake. It generalises the fixed 2:1, 3:1 and 4:1 datapath muxes into one block, used on pipelined MIPS datapath paths such as forwarding, ALU operand and write-register selection. It adds:
- back-pressure, through the valid/ready handshake;
- a defined result for every select value;
- a sticky error flag for illegal selects.

Parameters:
- WIDTH, 32, data width of each input and of the output.
- N_IN, 4, number of inputs (2..16).
- SEL_W, $clog2(N_IN) (min 1), select width; derived, not overridden.
- ILLEGAL_VAL, '0, value driven on out_data when the select is out of range.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  N_IN*WIDTH  flattened inputs; input k occupies [k*WIDTH +: WIDTH].
- in_sel  in  SEL_W  input index, sampled with the transfer.
- in_valid  in  1  upstream has a word.
- in_ready  out  1  block accepts a word this cycle.
- out_data  out  WIDTH  selected word.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts.
- sel_err  out  1  sticky: an illegal select was accepted.
- err_clr  in  1  synchronous clear of sel_err.

Behaviour:
- Reset: asynchronous, active-high, asserted at any time (including mid-transfer). Takes effect immediately and discards any held words.
  - out_valid=0, out_data=0, sel_err=0, skid buffer empty, in_ready=1 (asserted combinationally after rst deasserts).
- Transfers:
  - Input transfer when in_valid && in_ready on a rising clk.
  - Output transfer when out_valid && out_ready.
- Latency: 1 cycle. A word accepted at edge t is on out_data/out_valid after edge t.
- Throughput: one word per cycle while out_ready=1.
- Select decode:
  - in_sel < N_IN: word = input[in_sel].
  - in_sel >= N_IN (only possible when N_IN is not a power of two): word = ILLEGAL_VAL. The transfer still completes, and sel_err is set on that edge.
  - No latch, no X propagation for any select value.
- Data hold: out_data and out_valid stay stable while out_valid && !out_ready. A valid word is never dropped or duplicated.
- in_valid=0 or a refused word: in_data and in_sel are ignored; registers hold.
- sel_err:
  - Set on the edge an illegal word is accepted.
  - Cleared by err_clr=1.
  - Set and clear on the same edge: set wins.
- Storage states (with MUX_SKID_EN):
  - EMPTY. Accept → ONE.
  - ONE. Accept and drain → ONE. Drain only → EMPTY. Accept while stalled → TWO; the word goes to the skid register.
  - TWO. in_ready=0. Drain → ONE; the skid word moves to the output register on the same edge.
  - Order is strictly FIFO.

Optional Feature:
Macro MUX_SKID_EN.
- Defined:
  - 2-entry skid buffer as above.
  - in_ready is a register output (= !TWO), with no combinational path from out_ready.
  - Full throughput across stalls.
- Undefined:
  - Single output register.
  - in_ready = !out_valid || out_ready (combinational from out_ready).
  - Same latency, ordering, select and sel_err rules.

Decomposition:
- Package mux_pkg:
  - Constants DATA_W=32, REG_ADDR_W=5.
  - Function clog2_min1.
  - Enum skid_state_t {EMPTY, ONE, TWO}.
- Sub-module mux_skid_buf (WIDTH): the handshake and storage, instantiated by mux_pipe_n after the combinational select. Its body is chosen by MUX_SKID_EN.

Test Plan:
1. WIDTH=32, N_IN=4, out_ready=1. Inputs 0x11111111/0x22222222/0x33333333/0x44444444; in_sel 0,1,2,3 on consecutive cycles → out_data 0x11111111..0x44444444 one cycle later, 4 consecutive out_valid cycles, in_ready=1 throughout.
2. N_IN=3, WIDTH=5, in_sel=2'b11, in_valid=1 → out_data=5'd0, sel_err=1 next edge. Then err_clr=1 → sel_err=0. Illegal select with err_clr=1 on the same edge → sel_err=1.
3. MUX_SKID_EN defined, 3 words A, B, C issued back-to-back, out_ready=0 from the cycle after A is accepted:
   - A held on out_data, B in skid, in_ready=0, C held upstream.
   - Then out_ready=1 → A, B, C delivered in order, none lost.
4. MUX_SKID_EN undefined, out_valid=1, out_ready=0 → in_ready=0 in the same cycle. out_ready=1 → in_ready=1 in the same cycle, and a new word is accepted while the old one drains.
5. Assert rst asynchronously (between clk edges) while in TWO with sel_err=1 → out_valid=0, out_data=0, sel_err=0 immediately. After release, first accepted word appears one cycle later.
6. Random in_valid/out_ready/in_sel for 10k cycles vs. a queue model → identical output sequence, never more than 2 words held, no X on outputs after reset.
